// File: rtl/demux_buf_if.sv
// Producer/consumer bundle for demux_buf: one write port fanning out to 31 holding lanes.
// The err_cnt signal exists only when DEMUX_BUF_ERR_CNT_EN is defined.
interface demux_buf_if #(parameter int DW = 2);
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    sel;
    logic [DW-1:0] inp;
    logic [DW-1:0] out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7;
    logic [DW-1:0] out8,  out9,  out10, out11, out12, out13, out14, out15;
    logic [DW-1:0] out16, out17, out18, out19, out20, out21, out22, out23;
    logic [DW-1:0] out24, out25, out26, out27, out28, out29, out30;
    logic [30:0]   out_valid;
    logic [30:0]   out_ack;
    logic          sel_err;
`ifdef DEMUX_BUF_ERR_CNT_EN
    logic [7:0]    err_cnt;
`endif

    // Producer and lane consumers, seen from outside the block.
    modport master (
        output in_valid, sel, inp, out_ack,
        input  in_ready, out_valid, sel_err,
`ifdef DEMUX_BUF_ERR_CNT_EN
        input  err_cnt,
`endif
        input  out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
               out8,  out9,  out10, out11, out12, out13, out14, out15,
               out16, out17, out18, out19, out20, out21, out22, out23,
               out24, out25, out26, out27, out28, out29, out30
    );

    modport slave (
        input  in_valid, sel, inp, out_ack,
        output in_ready, out_valid, sel_err,
`ifdef DEMUX_BUF_ERR_CNT_EN
        output err_cnt,
`endif
        output out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
               out8,  out9,  out10, out11, out12, out13, out14, out15,
               out16, out17, out18, out19, out20, out21, out22, out23,
               out24, out25, out26, out27, out28, out29, out30
    );
endinterface

// File: rtl/demux_buf.sv
// One-write-per-cycle demultiplexer into 31 single-entry holding lanes with per-lane ack.
// Optional saturating illegal-select counter enabled by DEMUX_BUF_ERR_CNT_EN.
module demux_buf #(
    parameter int DW = 2
) (
    input logic       clk,
    input logic       rst_n,
    demux_buf_if.slave bus
);
    localparam int         NL          = 31;
    localparam logic [4:0] SEL_ILLEGAL = 5'd31;

    logic [NL-1:0][DW-1:0] data_q, data_d;
    logic [NL-1:0]         valid_q, valid_d;
    logic                  sel_err_q, sel_err_d;
    logic                  sel_legal, ready, wr_en;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that skips one infers a latch.
        sel_legal = (bus.sel != SEL_ILLEGAL);
        ready     = 1'b1;
        data_d    = data_q;
        valid_d   = valid_q & ~bus.out_ack;
        // Readiness depends only on lane state and ack, never on in_valid.
        if (sel_legal) begin
            ready = !valid_q[bus.sel] || bus.out_ack[bus.sel];
        end
        wr_en = bus.in_valid && ready && sel_legal;
        if (wr_en) begin
            valid_d[bus.sel] = 1'b1;
            data_d[bus.sel]  = bus.inp;
        end
        sel_err_d = bus.in_valid && !sel_legal;
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            // NOTE: lane data is reset as well, because the lanes are visible outputs that must read zero.
            data_q    <= '0;
            valid_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
        end
    end

`ifdef DEMUX_BUF_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts alongside the sel_err pulse it accompanies, sticking at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (sel_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.sel_err   = sel_err_q;

    assign bus.out0  = data_q[0];
    assign bus.out1  = data_q[1];
    assign bus.out2  = data_q[2];
    assign bus.out3  = data_q[3];
    assign bus.out4  = data_q[4];
    assign bus.out5  = data_q[5];
    assign bus.out6  = data_q[6];
    assign bus.out7  = data_q[7];
    assign bus.out8  = data_q[8];
    assign bus.out9  = data_q[9];
    assign bus.out10 = data_q[10];
    assign bus.out11 = data_q[11];
    assign bus.out12 = data_q[12];
    assign bus.out13 = data_q[13];
    assign bus.out14 = data_q[14];
    assign bus.out15 = data_q[15];
    assign bus.out16 = data_q[16];
    assign bus.out17 = data_q[17];
    assign bus.out18 = data_q[18];
    assign bus.out19 = data_q[19];
    assign bus.out20 = data_q[20];
    assign bus.out21 = data_q[21];
    assign bus.out22 = data_q[22];
    assign bus.out23 = data_q[23];
    assign bus.out24 = data_q[24];
    assign bus.out25 = data_q[25];
    assign bus.out26 = data_q[26];
    assign bus.out27 = data_q[27];
    assign bus.out28 = data_q[28];
    assign bus.out29 = data_q[29];
    assign bus.out30 = data_q[30];
endmodule

// File: tb/tb_demux_buf.sv
// Directed bench for demux_buf: a lane model plus a write scoreboard drained the cycle after each handshake.
// err_cnt checks are compiled in only when DEMUX_BUF_ERR_CNT_EN is defined.
module tb_demux_buf;
    localparam int DW = 2;
    localparam int NL = 31;

    typedef struct {
        int            lane;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_buf_if #(.DW(DW)) bus ();

    demux_buf #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] outs [NL];
    assign outs[0]  = bus.out0;   assign outs[1]  = bus.out1;   assign outs[2]  = bus.out2;
    assign outs[3]  = bus.out3;   assign outs[4]  = bus.out4;   assign outs[5]  = bus.out5;
    assign outs[6]  = bus.out6;   assign outs[7]  = bus.out7;   assign outs[8]  = bus.out8;
    assign outs[9]  = bus.out9;   assign outs[10] = bus.out10;  assign outs[11] = bus.out11;
    assign outs[12] = bus.out12;  assign outs[13] = bus.out13;  assign outs[14] = bus.out14;
    assign outs[15] = bus.out15;  assign outs[16] = bus.out16;  assign outs[17] = bus.out17;
    assign outs[18] = bus.out18;  assign outs[19] = bus.out19;  assign outs[20] = bus.out20;
    assign outs[21] = bus.out21;  assign outs[22] = bus.out22;  assign outs[23] = bus.out23;
    assign outs[24] = bus.out24;  assign outs[25] = bus.out25;  assign outs[26] = bus.out26;
    assign outs[27] = bus.out27;  assign outs[28] = bus.out28;  assign outs[29] = bus.out29;
    assign outs[30] = bus.out30;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_data [NL];
    logic [30:0]   exp_valid;
    logic          exp_err;
    int            exp_cnt;
    wr_t           sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("%s_out%0d", tag, i), 32'(outs[i]), 32'(exp_data[i]));
        end
    endtask

    // Drive one cycle of stimulus, check in_ready, clock it, update model, check outputs.
    task automatic cycle(input logic v, input logic [4:0] s, input logic [DW-1:0] d,
                         input logic [30:0] ack, input logic rst);
        logic exp_ready;
        wr_t  w;
        bus.in_valid = v;
        bus.sel      = s;
        bus.inp      = d;
        bus.out_ack  = ack;
        rst_n        = rst;
        #1;
        exp_ready = (s == 5'd31) ? 1'b1 : (!exp_valid[s] || ack[s]);
        check($sformatf("in_ready_sel%0d", s), 32'(bus.in_ready), 32'(exp_ready));
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NL; i++) exp_data[i] = '0;
            exp_valid = '0;
            exp_err   = 1'b0;
            exp_cnt   = 0;
            sb.delete();
        end else begin
            exp_valid = exp_valid & ~ack;
            exp_err   = v && (s == 5'd31);
            if (exp_err && exp_cnt != 255) exp_cnt++;
            if (v && exp_ready && s != 5'd31) begin
                exp_valid[s] = 1'b1;
                exp_data[s]  = d;
                w.lane = int'(s);
                w.data = d;
                sb.push_back(w);
            end
        end
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("sel_err", 32'(bus.sel_err), 32'(exp_err));
`ifdef DEMUX_BUF_ERR_CNT_EN
        check("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
`endif
        while (sb.size() > 0) begin
            w = sb.pop_front();
            check($sformatf("wr_data_lane%0d", w.lane), 32'(outs[w.lane]), 32'(w.data));
            check($sformatf("wr_valid_lane%0d", w.lane), 32'(bus.out_valid[w.lane]), 32'd1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.sel      = '0;
        bus.inp      = '0;
        bus.out_ack  = '0;
        rst_n        = 1'b0;
        for (int i = 0; i < NL; i++) exp_data[i] = '0;
        exp_valid = '0;
        exp_err   = 1'b0;
        exp_cnt   = 0;

        // Reset, with a write presented that must be discarded.
        cycle(1'b0, 5'd0, 2'b00, 31'h0, 1'b0);
        cycle(1'b1, 5'd3, 2'b11, 31'h0, 1'b0);
        check_all("reset");
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        cycle(1'b0, 5'd9, 2'b00, 31'h0, 1'b1);

        // Basic write to lane 5.
        cycle(1'b1, 5'd5, 2'b10, 31'h0, 1'b1);
        check("w5_valid", 32'(bus.out_valid), 32'h20);
        check("w5_data", 32'(bus.out5), 32'h2);
        check_all("w5");

        // Consume lane 5, then ack it again while empty: data retained.
        cycle(1'b0, 5'd0, 2'b00, 31'h20, 1'b1);
        cycle(1'b0, 5'd0, 2'b00, 31'h20, 1'b1);
        check("ack_empty_data5", 32'(bus.out5), 32'h2);

        // Stall on full lane 7, then ack releases it in the same cycle.
        cycle(1'b1, 5'd7, 2'b11, 31'h0, 1'b1);
        cycle(1'b1, 5'd7, 2'b01, 31'h0, 1'b1);
        cycle(1'b1, 5'd7, 2'b01, 31'h0, 1'b1);
        check("stall_data7", 32'(bus.out7), 32'h3);
        cycle(1'b1, 5'd7, 2'b01, 31'h80, 1'b1);
        check("release_data7", 32'(bus.out7), 32'h1);

        // Write and ack to lane 12 in one cycle: write wins.
        cycle(1'b1, 5'd12, 2'b01, 31'h0, 1'b1);
        cycle(1'b1, 5'd12, 2'b11, 31'h1000, 1'b1);
        check("wr_ack12_valid", 32'(bus.out_valid[12]), 32'h1);
        check("wr_ack12_data", 32'(bus.out12), 32'h3);

        // Write to lane 3 while acks drain lanes 7 and 12.
        cycle(1'b1, 5'd3, 2'b10, 31'h1080, 1'b1);
        check_all("multi_ack");

        // Illegal select: three pulses, lanes untouched, then idle.
        cycle(1'b1, 5'd31, 2'b11, 31'h0, 1'b1);
        cycle(1'b1, 5'd31, 2'b11, 31'h0, 1'b1);
        cycle(1'b1, 5'd31, 2'b11, 31'h0, 1'b1);
        check_all("sel31");
`ifdef DEMUX_BUF_ERR_CNT_EN
        check("err_cnt_3", 32'(bus.err_cnt), 32'd3);
        for (int k = 0; k < 300; k++) cycle(1'b1, 5'd31, 2'b00, 31'h0, 1'b1);
        check("err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif
        cycle(1'b0, 5'd31, 2'b00, 31'h0, 1'b1);

        // Fill the edge lanes, then reset with a concurrent write and acks.
        cycle(1'b1, 5'd0, 2'b01, 31'h0, 1'b1);
        cycle(1'b1, 5'd30, 2'b10, 31'h0, 1'b1);
        cycle(1'b1, 5'd4, 2'b11, 31'h7FFF_FFFF, 1'b0);
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        check_all("midrst");

        // Sweep every legal lane with no acks.
        for (int i = 0; i < NL; i++) begin
            logic [4:0] s;
            s = 5'(i);
            cycle(1'b1, s, s[1:0], 31'h0, 1'b1);
        end
        check("sweep_valid", 32'(bus.out_valid), 32'h7FFF_FFFF);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("sweep_out%0d", i), 32'(outs[i]), 32'(i % 4));
        end

        // All lanes full: illegal select is still accepted.
        cycle(1'b1, 5'd31, 2'b00, 31'h0, 1'b1);
        cycle(1'b0, 5'd0, 2'b00, 31'h0, 1'b1);
        check_all("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_buf.md
DEMUX_BUF -- requirements
Module: demux_buf

Interface
REQ-001 SHALL have parameter: DW, 2, data width of inp and of each output lane.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  write request from producer.
REQ-005 SHALL have port: in_ready  output  1  block can accept a write to lane sel this cycle.
REQ-006 SHALL have port: sel  input  5  destination lane index, 0..30 legal, 31 illegal.
REQ-007 SHALL have port: inp  input  DW  write data.
REQ-008 SHALL have ports: out0..out30  output  DW each  per-lane holding registers.
REQ-009 SHALL have port: out_valid  output  31  bit i set = lane i holds unconsumed data.
REQ-010 SHALL have port: out_ack  input  31  bit i = consumer of lane i takes data this cycle.
REQ-011 SHALL have port: sel_err  output  1  one-cycle pulse on write attempt with sel=31.
REQ-012 SHALL have port (macro-gated, REQ-030): err_cnt  output  8  saturating illegal-select count.

Function
REQ-013 SHALL, for legal sel, drive in_ready = !out_valid[sel] | out_ack[sel] (combinational).
REQ-014 SHALL, for sel=31, drive in_ready = 1 (request drained, data discarded).
REQ-015 SHALL complete a write when in_valid & in_ready & sel<=30: next cycle out<sel>=inp, out_valid[sel]=1.
REQ-016 SHALL leave every non-selected lane's data and valid bit unchanged on a write.
REQ-017 SHALL clear out_valid[i] the cycle after out_ack[i]=1 while out_valid[i]=1, absent a same-cycle write to lane i.
REQ-018 SHALL, on same-cycle write and ack to one lane, keep out_valid[i]=1 and load new data (write wins).
REQ-019 SHALL ignore out_ack[i] when out_valid[i]=0; out<i> data retained.
REQ-020 SHALL retain out<i> value after consumption until next write to lane i.
REQ-021 SHALL, when in_valid=1 and sel=31, assert sel_err for exactly the following cycle; no lane modified.
REQ-022 SHALL stall (no state change, in_ready=0) when target lane valid and not acked; producer holds sel/inp/in_valid.
REQ-023 SHALL have write latency of one cycle: data visible on out<i> the cycle after handshake.
REQ-024 SHALL process at most one write per cycle; concurrent acks to any subset of lanes allowed.
REQ-025 SHALL not assert in_ready dependence on in_valid (no combinational loop through producer).

Reset
REQ-026 SHALL, while rst_n=0 at a rising clk edge, set out0..out30=0, out_valid=0, sel_err=0, err_cnt=0.
REQ-027 SHALL discard any write or ack presented in a cycle where rst_n=0 (reset mid-operation wins).
REQ-028 SHALL drive in_ready from reset state (all lanes empty) the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL use macro DEMUX_BUF_ERR_CNT_EN.
REQ-030 SHALL, with DEMUX_BUF_ERR_CNT_EN defined, increment err_cnt on each sel_err pulse, saturating at 255; without it, err_cnt port and counter absent, sel_err unaffected.

Verification
REQ-031 SHALL cover: reset, in_valid=1 sel=5 inp=2'b10 -> next cycle out5=2'b10, out_valid=31'h20, other lanes 0.
REQ-032 SHALL cover: lane 7 full, write sel=7 inp=2'b01 no ack -> in_ready=0, out7 unchanged; ack then -> write completes next cycle.
REQ-033 SHALL cover: lane 12 full, same-cycle out_ack[12]=1 and write inp=2'b11 -> out12=2'b11, out_valid[12] stays 1.
REQ-034 SHALL cover: in_valid=1 sel=31 x3 -> three sel_err pulses, out_valid unchanged, err_cnt=3 (macro on); 300 pulses -> err_cnt=255.
REQ-035 SHALL cover: writes to lanes 0 and 30 then rst_n=0 one cycle with concurrent write -> all outputs 0, out_valid=0.
REQ-036 SHALL cover: sweep sel 0..30 with inp=sel[1:0], no acks -> out_valid=31'h7FFFFFFF, each out<i>=i mod 4.
